// File: rtl/debnc_pkg.sv
// Shared types and helpers for the time-multiplexed switch debouncer.
package debnc_pkg;

    // Scan sequencer: idle between ticks, then one pass over all channels.
    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    // Width of a stability counter able to hold 0..stable.
    function automatic int cnt_width(input int stable);
        return (stable > 0) ? $clog2(stable + 1) : 1;
    endfunction

endpackage

// File: rtl/debnc_tick_gen.sv
// Sample-tick generator: mod-M counter, one-cycle tick on the last count,
// held at zero while disabled.
module debnc_tick_gen #(
    parameter int M = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int W = (M > 1) ? $clog2(M) : 1;
    localparam logic [W-1:0] LAST = W'(M - 1);

    logic [W-1:0] count;

    // Free-running count while enabled, wraps after LAST, cleared when disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (!en || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

    // Tick is only meaningful while enabled.
    always_comb begin
        tick = en && (count == LAST);
    end

endmodule

// File: rtl/debnc_scan_ctrl.sv
// Debounce controller: synchronises N_CH raw switches, scans one channel per
// cycle after each sample tick, and reports debounced level changes as
// round-robin arbitrated valid/ready events.
module debnc_scan_ctrl
    import debnc_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int TICK_M     = 1000000,
    parameter int STABLE_CNT = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [N_CH-1:0]         sw,
    output logic [N_CH-1:0]         db,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [$clog2(N_CH)-1:0] evt_ch,
    output logic                    evt_level,
    output logic                    evt_ovf,
    input  logic                    clr_ovf
);

    localparam int IDX_W = $clog2(N_CH);
    localparam int CNT_W = cnt_width(STABLE_CNT);
    localparam logic [IDX_W-1:0] LAST_CH  = IDX_W'(N_CH - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

    logic [N_CH-1:0]  sync1;
    logic [N_CH-1:0]  s;
    logic             tick;

    scan_state_t      state;
    scan_state_t      state_n;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_n;
    logic             proc;

    logic [CNT_W-1:0] cnt [N_CH];
    logic [N_CH-1:0]  lvl;
    logic [N_CH-1:0]  pending;
    logic [N_CH-1:0]  pending_n;

    logic             differs;
    logic             flip;
    logic             accept;
    logic             ovf_set;

    logic [IDX_W-1:0] rr_ptr;
    logic             stale;
    logic             pick_found;
    logic [IDX_W-1:0] pick_ch;
    int unsigned      cand;

    // Two-flop synchroniser for the asynchronous switch inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            s     <= '0;
        end else begin
            sync1 <= sw;
            s     <= sync1;
        end
    end

    debnc_tick_gen #(
        .M(TICK_M)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (tick)
    );

    // Scan sequencer state and channel index registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
        end
    end

    // Scan next-state: start on tick, visit each channel once, then idle.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        proc    = 1'b0;
        case (state)
            IDLE: begin
                if (tick) begin
                    state_n = SCAN;
                    idx_n   = '0;
                end
            end
            SCAN: begin
                proc = 1'b1;
                if (idx == LAST_CH) begin
                    state_n = IDLE;
                    idx_n   = '0;
                end else begin
                    idx_n = idx + IDX_W'(1);
                end
            end
        endcase
    end

    // Decision for the channel currently under scan, plus pending bookkeeping.
    always_comb begin
        differs   = s[idx] != db[idx];
        flip      = proc && differs && (cnt[idx] == CNT_LAST);
        accept    = evt_valid && evt_ready;
        // A flip on a still-pending channel overflows, except when that very
        // event is being accepted in the same cycle (the re-set replaces it).
        ovf_set   = flip && pending[idx] && !(accept && evt_ch == idx);
        pending_n = pending;
        // A stale presented event keeps its pending bit so the newer level
        // is delivered afterwards.
        if (accept && !stale) begin
            pending_n[evt_ch] = 1'b0;
        end
        if (flip) begin
            pending_n[idx] = 1'b1;
        end
    end

    // Per-channel stability counter, debounced level and event level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db  <= '0;
            lvl <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                cnt[i] <= '0;
            end
        end else if (proc) begin
            if (!differs) begin
                cnt[idx] <= '0;
            end else if (cnt[idx] == CNT_LAST) begin
                db[idx]  <= ~db[idx];
                lvl[idx] <= ~db[idx];
                cnt[idx] <= '0;
            end else begin
                cnt[idx] <= cnt[idx] + CNT_W'(1);
            end
        end
    end

    // Pending event flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_n;
        end
    end

    // Round-robin pick: first pending channel at or after rr_ptr, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_ch    = rr_ptr;
        cand       = 0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            cand = (rr_ptr + k) % N_CH;
            if (!pick_found && pending[cand]) begin
                pick_found = 1'b1;
                pick_ch    = IDX_W'(cand);
            end
        end
    end

    // Registered event port with round-robin pointer update on acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_valid <= 1'b0;
            evt_ch    <= '0;
            evt_level <= 1'b0;
            rr_ptr    <= '0;
            stale     <= 1'b0;
        end else if (accept) begin
            evt_valid <= 1'b0;
            rr_ptr    <= (evt_ch == LAST_CH) ? '0 : evt_ch + IDX_W'(1);
            stale     <= 1'b0;
        end else if (!evt_valid && pick_found) begin
            evt_valid <= 1'b1;
            evt_ch    <= pick_ch;
            evt_level <= lvl[pick_ch];
            // Level written this same cycle is newer than what gets latched.
            stale     <= flip && (idx == pick_ch);
        end else if (evt_valid && flip && (idx == evt_ch)) begin
            stale <= 1'b1;
        end
    end

    // Sticky overflow flag; a new overflow beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_ovf <= 1'b0;
        end else if (ovf_set) begin
            evt_ovf <= 1'b1;
        end else if (clr_ovf) begin
            evt_ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_debnc_scan_ctrl.sv
// Self-checking bench for debnc_scan_ctrl (N_CH=4, TICK_M=8, STABLE_CNT=3).
module tb_debnc_scan_ctrl;

    localparam int N_CH       = 4;
    localparam int TICK_M     = 8;
    localparam int STABLE_CNT = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] sw;
    logic [3:0] db;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_ch;
    logic       evt_level;
    logic       evt_ovf;
    logic       clr_ovf;

    always #5 clk = ~clk;

    debnc_scan_ctrl #(
        .N_CH       (N_CH),
        .TICK_M     (TICK_M),
        .STABLE_CNT (STABLE_CNT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sw        (sw),
        .db        (db),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_ch    (evt_ch),
        .evt_level (evt_level),
        .evt_ovf   (evt_ovf),
        .clr_ovf   (clr_ovf)
    );

    typedef struct packed {
        logic [1:0] ch;
        logic       level;
    } evt_t;

    typedef struct {
        logic [3:0] sw;
        logic [3:0] exp_db;
    } vec_t;

    evt_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int ch, input logic level);
        evt_t e;
        e.ch    = 2'(ch);
        e.level = level;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        en        = 1'b1;
        sw        = 4'b0000;
        evt_ready = 1'b1;
        clr_ovf   = 1'b0;
        step(3);
        exp_q.delete();
        rst = 1'b0;
    endtask

    // Event monitor: pops the scoreboard on each handshake, checks stability
    // while stalled and the mandatory idle cycle after acceptance.
    initial begin
        evt_t e;
        evt_t prev_evt;
        logic prev_hold;
        logic prev_acc;
        prev_hold = 1'b0;
        prev_acc  = 1'b0;
        prev_evt  = '0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                prev_hold = 1'b0;
                prev_acc  = 1'b0;
            end else begin
                if (prev_acc) check("valid_gap", evt_valid, 1'b0);
                if (prev_hold) begin
                    check("hold_valid", evt_valid, 1'b1);
                    check("hold_ch", evt_ch, prev_evt.ch);
                    check("hold_level", evt_level, prev_evt.level);
                end
                if (evt_valid === 1'b1) check("valid_expected", exp_q.size() != 0, 1'b1);
                if (evt_valid === 1'b1 && evt_ready === 1'b1 && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("evt_ch", evt_ch, e.ch);
                    check("evt_level", evt_level, e.level);
                end
                prev_hold      = (evt_valid === 1'b1) && !evt_ready;
                prev_acc       = (evt_valid === 1'b1) && evt_ready;
                prev_evt.ch    = evt_ch;
                prev_evt.level = evt_level;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        logic [3:0] prev_sw;
        int valid_seen;

        vecs[0] = '{4'b0000, 4'b0000};
        vecs[1] = '{4'b0100, 4'b0100};
        vecs[2] = '{4'b0110, 4'b0110};
        vecs[3] = '{4'b1111, 4'b1111};
        vecs[4] = '{4'b0000, 4'b0000};
        vecs[5] = '{4'b1010, 4'b1010};
        vecs[6] = '{4'b0101, 4'b0101};
        vecs[7] = '{4'b0000, 4'b0000};

        // Reset state and a quiet run.
        rst = 1'b1; en = 1'b1; sw = '0; evt_ready = 1'b1; clr_ovf = 1'b0;
        step(2);
        check("rst_db", db, 4'b0000);
        check("rst_valid", evt_valid, 1'b0);
        check("rst_ch", evt_ch, 2'd0);
        check("rst_level", evt_level, 1'b0);
        check("rst_ovf", evt_ovf, 1'b0);
        do_reset();
        valid_seen = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (evt_valid) valid_seen++;
        end
        check("quiet_valid", valid_seen, 0);
        check("quiet_db", db, 4'b0000);
        check("quiet_ovf", evt_ovf, 1'b0);

        // Table-driven level patterns with the consumer always ready.
        prev_sw = 4'b0000;
        for (int v = 0; v < 8; v++) begin
            for (int j = 0; j < 4; j++) begin
                if (vecs[v].sw[j] != prev_sw[j]) push(j, vecs[v].sw[j]);
            end
            sw = vecs[v].sw;
            prev_sw = vecs[v].sw;
            step(56);
            check("vec_db", db, vecs[v].exp_db);
            check("vec_drained", exp_q.size(), 0);
            check("vec_ovf", evt_ovf, 1'b0);
        end

        // Exact latency: ticks after edges 7/15/23, ch2 scanned 4 edges later.
        do_reset();
        sw = 4'b0100;
        push(2, 1'b1);
        step(26);
        check("lat_db_before", db, 4'b0000);
        step(1);
        check("lat_db_flip", db, 4'b0100);
        check("lat_valid_lag", evt_valid, 1'b0);
        step(1);
        check("lat_valid", evt_valid, 1'b1);
        check("lat_ch", evt_ch, 2'd2);
        check("lat_level", evt_level, 1'b1);
        step(40);
        check("lat_drained", exp_q.size(), 0);

        // Bounce on sw[1]: period-6 toggling never gives 3 equal samples.
        do_reset();
        for (int t = 0; t < 14; t++) begin
            sw[1] = ~sw[1];
            step(3);
        end
        sw[1] = 1'b0;
        step(10);
        check("bounce_db", db, 4'b0000);
        sw[1] = 1'b1;
        push(1, 1'b1);
        step(17);
        check("bounce_early", db[1], 1'b0);
        step(40);
        check("bounce_final", db, 4'b0010);
        check("bounce_drained", exp_q.size(), 0);

        // Two simultaneous presses under back-pressure.
        do_reset();
        evt_ready = 1'b0;
        sw = 4'b1001;
        push(0, 1'b1);
        push(3, 1'b1);
        step(60);
        check("bp_valid", evt_valid, 1'b1);
        check("bp_ch", evt_ch, 2'd0);
        check("bp_level", evt_level, 1'b1);
        evt_ready = 1'b1;
        step(20);
        check("bp_drained", exp_q.size(), 0);
        check("bp_rr", dut.rr_ptr, 2'd0);

        // Press then release while the press is still pending.
        do_reset();
        evt_ready = 1'b0;
        sw = 4'b0010;
        push(1, 1'b1);
        for (int i = 0; i < 100 && db[1] !== 1'b1; i++) step(1);
        check("ovf_rise", db[1], 1'b1);
        sw = 4'b0000;
        push(1, 1'b0);
        step(50);
        check("ovf_db", db, 4'b0000);
        check("ovf_set", evt_ovf, 1'b1);
        check("ovf_ch", evt_ch, 2'd1);
        check("ovf_level_held", evt_level, 1'b1);
        evt_ready = 1'b1;
        step(20);
        check("ovf_drained", exp_q.size(), 0);
        check("ovf_sticky", evt_ovf, 1'b1);
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        check("ovf_clr", evt_ovf, 1'b0);

        // Disabled ticking, then reset during a stalled handshake.
        do_reset();
        en = 1'b0;
        sw = 4'b0100;
        step(60);
        check("en0_db", db, 4'b0000);
        check("en0_count", dut.u_tick.count, 0);
        en = 1'b1;
        evt_ready = 1'b0;
        push(2, 1'b1);
        for (int i = 0; i < 80 && evt_valid !== 1'b1; i++) step(1);
        check("rst_hs_valid", evt_valid, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_hs_db", db, 4'b0000);
        check("rst_hs_valid0", evt_valid, 1'b0);
        check("rst_hs_ch", evt_ch, 2'd0);
        check("rst_hs_level", evt_level, 1'b0);
        check("rst_hs_ovf", evt_ovf, 1'b0);
        exp_q.delete();
        step(2);
        sw = 4'b0000;
        rst = 1'b0;
        step(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
